// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types: bubble encoding, fetch FSM states and the IF/ID record.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a new record, hold, or replace the instruction with a bubble.
module if_fetch_stage_ifid_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q_q;
  ifid_t q_d;

  // A bubble keeps PC_id so decode still sees a sensible PC alongside the NOP.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.instr = NOP_INSTR;
    end else if (load_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= '{instr: NOP_INSTR, pc: 32'h0000_0000};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem req/ready handshake, one-entry hold buffer and IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  ifid_t        buf_q, buf_d;
  logic         busy_q;

  logic         redirect_s, complete_s, pending_s;
  logic [31:0]  jump_tgt_s;
  logic         ifid_load_s, ifid_flush_s;
  ifid_t        ifid_in_s, ifid_q_s;

  assign redirect_s = IFWrite & (Branch | Jump);
  assign complete_s = req_q & imem_ready;
  assign pending_s  = req_q & ~imem_ready;
  assign jump_tgt_s = align_word(JumpAddr);

  // pc_q is the address on the bus; during DRAIN the redirect target waits in target_q.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    buf_d        = buf_q;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_in_s    = '{instr: imem_rdata, pc: pc_q};
    if (redirect_s) begin
      ifid_flush_s = 1'b1;
      if (pending_s) begin
        state_d  = DRAIN;
        target_d = jump_tgt_s;
      end else begin
        state_d = FETCH;
        pc_d    = jump_tgt_s;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (complete_s && IFWrite) begin
            ifid_load_s = 1'b1;
            pc_d        = pc_q + 32'd4;
          end else if (complete_s) begin
            buf_d   = '{instr: imem_rdata, pc: pc_q};
            state_d = HOLD;
          end else if (IFWrite) begin
            ifid_flush_s = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (IFWrite) begin
            ifid_in_s   = buf_q;
            ifid_load_s = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        DRAIN: begin
          ifid_flush_s = IFWrite;
          if (complete_s) begin
            pc_d    = target_q;
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
    req_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      buf_q    <= '{instr: NOP_INSTR, pc: 32'h0000_0000};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      buf_q    <= buf_d;
      busy_q   <= pending_s;
    end
  end

  if_fetch_stage_ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (ifid_load_s),
    .flush_i(ifid_flush_s),
    .d_i    (ifid_in_s),
    .q_o    (ifid_q_s)
  );

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign fetch_busy     = busy_q;
  assign Instruction_id = ifid_q_s.instr;
  assign PC_id          = ifid_q_s.pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized program-order scoreboard.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        IFWrite;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_id;
  logic [31:0] PC_id;
  logic        fetch_busy;

  int checks;
  int failures;

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .IFWrite       (IFWrite),
    .Branch        (Branch),
    .Jump          (Jump),
    .JumpAddr      (JumpAddr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .Instruction_id(Instruction_id),
    .PC_id         (PC_id),
    .fetch_busy    (fetch_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: top byte 0xC3 guarantees no word ever looks like the NOP bubble.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {8'hC3, a[25:2]};
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, release, and stop at the first cycle where address RESET_PC is requested.
  task automatic start();
    reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0;
    JumpAddr = 32'h0; imem_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0;
    JumpAddr = 32'h0; imem_ready = 1'b1;
    step();
    step();
    checks++; if (Instruction_id !== NOP) begin failures++; $display("FAIL reset_instr: got %h want %h", Instruction_id, NOP); end
    checks++; if (PC_id !== 32'h0) begin failures++; $display("FAIL reset_pc_id: got %h want %h", PC_id, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
    checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", fetch_busy); end
    reset = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'h0); end
  endtask

  task automatic test_straight_line();
    logic [31:0] a;
    logic [31:0] p;
    start();
    for (int i = 0; i < 6; i++) begin
      a = 32'(i) * 32'd4;
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin failures++; $display("FAIL line_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, a); end
      if (i > 0) begin
        p = a - 32'd4;
        checks++; if (PC_id !== p || Instruction_id !== mem_f(p)) begin failures++; $display("FAIL line_ifid[%0d]: got %h/%h want %h/%h", i, PC_id, Instruction_id, p, mem_f(p)); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    start();
    step();
    step();
    IFWrite = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b want 0", imem_req); end
    checks++; if (PC_id !== 32'h4 || Instruction_id !== mem_f(32'h4)) begin failures++; $display("FAIL stall_hold1: got %h/%h want %h/%h", PC_id, Instruction_id, 32'h4, mem_f(32'h4)); end
    step();
    checks++; if (PC_id !== 32'h4 || Instruction_id !== mem_f(32'h4) || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold2: got %h/%h req=%b want %h/%h req=0", PC_id, Instruction_id, imem_req, 32'h4, mem_f(32'h4)); end
    IFWrite = 1'b1;
    step();
    checks++; if (PC_id !== 32'h8 || Instruction_id !== mem_f(32'h8)) begin failures++; $display("FAIL stall_release: got %h/%h want %h/%h", PC_id, Instruction_id, 32'h8, mem_f(32'h8)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL stall_refetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'hC); end
    step();
    checks++; if (PC_id !== 32'hC) begin failures++; $display("FAIL stall_next: got %h want %h", PC_id, 32'hC); end
  endtask

  task automatic test_branch();
    start();
    step();
    step();
    Branch = 1'b1; JumpAddr = 32'h0000_0043;
    step();
    Branch = 1'b0;
    checks++; if (Instruction_id !== NOP) begin failures++; $display("FAIL branch_bubble: got %h want %h", Instruction_id, NOP); end
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin failures++; $display("FAIL branch_target: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'h40); end
    step();
    checks++; if (PC_id !== 32'h40 || Instruction_id !== mem_f(32'h40)) begin failures++; $display("FAIL branch_first: got %h/%h want %h/%h", PC_id, Instruction_id, 32'h40, mem_f(32'h40)); end
  endtask

  task automatic test_drain(input bit overwrite);
    logic [31:0] tgt;
    tgt = overwrite ? 32'h0000_00C0 : 32'h0000_0080;
    start();
    for (int i = 0; i < 4; i++) step();
    imem_ready = 1'b0; Jump = 1'b1; JumpAddr = 32'h0000_0080;
    step();
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1 || Instruction_id !== NOP) begin failures++; $display("FAIL drain_c1: got addr=%h req=%b instr=%h want addr=%h req=1 instr=%h", imem_addr, imem_req, Instruction_id, 32'h10, NOP); end
    checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL drain_busy: got %b want 1", fetch_busy); end
    Jump = overwrite; JumpAddr = 32'h0000_00C0;
    step();
    Jump = 1'b0;
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL drain_c2: got %h want %h", imem_addr, 32'h10); end
    step();
    checks++; if (imem_addr !== 32'h10 || Instruction_id !== NOP) begin failures++; $display("FAIL drain_c3: got addr=%h instr=%h want addr=%h instr=%h", imem_addr, Instruction_id, 32'h10, NOP); end
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== tgt || Instruction_id !== NOP || fetch_busy !== 1'b0) begin failures++; $display("FAIL drain_redirect: got addr=%h instr=%h busy=%b want addr=%h instr=%h busy=0", imem_addr, Instruction_id, fetch_busy, tgt, NOP); end
    step();
    checks++; if (PC_id !== tgt || Instruction_id !== mem_f(tgt)) begin failures++; $display("FAIL drain_first: got %h/%h want %h/%h", PC_id, Instruction_id, tgt, mem_f(tgt)); end
  endtask

  task automatic test_stall_redirect();
    start();
    step();
    step();
    IFWrite = 1'b0; Branch = 1'b1; JumpAddr = 32'h0000_0200;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8 || PC_id !== 32'h4) begin failures++; $display("FAIL stallbr_ignored: got req=%b addr=%h pc_id=%h want req=0 addr=%h pc_id=%h", imem_req, imem_addr, PC_id, 32'h8, 32'h4); end
    IFWrite = 1'b1;
    step();
    Branch = 1'b0;
    checks++; if (Instruction_id !== NOP || imem_addr !== 32'h200 || imem_req !== 1'b1) begin failures++; $display("FAIL stallbr_taken: got instr=%h addr=%h req=%b want instr=%h addr=%h req=1", Instruction_id, imem_addr, imem_req, NOP, 32'h200); end
    step();
    checks++; if (PC_id !== 32'h200 || Instruction_id !== mem_f(32'h200)) begin failures++; $display("FAIL stallbr_first: got %h/%h want %h/%h", PC_id, Instruction_id, 32'h200, mem_f(32'h200)); end
  endtask

  task automatic test_reset_mid();
    start();
    for (int i = 0; i < 4; i++) step();
    imem_ready = 1'b0; Jump = 1'b1; JumpAddr = 32'h0000_0080;
    step();
    Jump = 1'b0; reset = 1'b1;
    step();
    checks++; if (Instruction_id !== NOP || PC_id !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_busy !== 1'b0) begin failures++; $display("FAIL midreset_vals: got instr=%h pc=%h req=%b addr=%h busy=%b want %h/0/0/0/0", Instruction_id, PC_id, imem_req, imem_addr, fetch_busy, NOP); end
    reset = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL midreset_fetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'h0); end
    step();
    checks++; if (PC_id !== 32'h0 || Instruction_id !== mem_f(32'h0)) begin failures++; $display("FAIL midreset_first: got %h/%h want %h/%h", PC_id, Instruction_id, 32'h0, mem_f(32'h0)); end
  endtask

  task automatic test_wrap();
    start();
    step();
    step();
    Jump = 1'b1; JumpAddr = 32'hFFFF_FFF8;
    step();
    Jump = 1'b0;
    step();
    step();
    checks++; if (imem_addr !== 32'h0 || PC_id !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got addr=%h pc_id=%h want addr=%h pc_id=%h", imem_addr, PC_id, 32'h0, 32'hFFFF_FFFC); end
    step();
    checks++; if (PC_id !== 32'h0 || Instruction_id !== mem_f(32'h0)) begin failures++; $display("FAIL wrap_pc: got %h/%h want %h/%h", PC_id, Instruction_id, 32'h0, mem_f(32'h0)); end
  endtask

  // Program-order scoreboard: every instruction decode consumes must be the next one in program order.
  task automatic test_random();
    logic [31:0] model_pc;
    logic [31:0] p_addr;
    logic        p_req;
    logic        p_rdy;
    int          delivered;
    bit          consume;
    bit          redir;
    start();
    model_pc = 32'h0; p_addr = 32'h0; p_req = 1'b0; p_rdy = 1'b0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        checks++; if (fetch_busy !== (p_req & ~p_rdy)) begin failures++; $display("FAIL rnd_busy[%0d]: got %b want %b", cyc, fetch_busy, p_req & ~p_rdy); end
        if (p_req && !p_rdy) begin
          checks++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin failures++; $display("FAIL rnd_stable[%0d]: got req=%b addr=%h want req=1 addr=%h", cyc, imem_req, imem_addr, p_addr); end
        end
      end
      checks++; if (imem_addr[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align[%0d]: got %h", cyc, imem_addr); end
      IFWrite    = ($urandom_range(0, 3) != 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      JumpAddr   = $urandom;
      Branch     = 1'b0;
      Jump       = 1'b0;
      consume    = IFWrite && (Instruction_id !== NOP);
      redir      = consume && ($urandom_range(0, 7) == 0);
      if (redir) begin
        if ($urandom_range(0, 1) == 0) Branch = 1'b1;
        else Jump = 1'b1;
      end else if (!IFWrite && $urandom_range(0, 3) == 0) begin
        Branch = 1'b1;
      end
      if (consume) begin
        delivered++;
        checks++; if (PC_id !== model_pc || Instruction_id !== mem_f(model_pc)) begin failures++; $display("FAIL rnd_order[%0d]: got %h/%h want %h/%h", cyc, PC_id, Instruction_id, model_pc, mem_f(model_pc)); end
        model_pc = redir ? {JumpAddr[31:2], 2'b00} : model_pc + 32'd4;
      end
      p_req = imem_req; p_rdy = imem_ready; p_addr = imem_addr;
      step();
    end
    checks++; if (delivered < 300) begin failures++; $display("FAIL rnd_progress: got %0d delivered want >= 300", delivered); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_straight_line();
    test_stall();
    test_branch();
    test_drain(1'b0);
    test_drain(1'b1);
    test_stall_redirect();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name:
if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. It is the consumer of the decode stage's `IFWrite`, `Branch`, `Jump` and `JumpAddr` outputs.
- Owns the PC register and the instruction-memory request/ready handshake.
- Owns a one-entry hold buffer and the IF/ID pipeline register that drives `Instruction_id` and `PC_id` into decode.
- Applies stalls, and flushes wrong-path fetches on taken branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble inserted on flush or empty fetch (`addi x0,x0,0`).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- IFWrite  in  1  1 = decode accepts a new instruction this cycle; 0 = stall and hold IF/ID.
- Branch  in  1  taken conditional branch in decode.
- Jump  in  1  JAL/JALR in decode.
- JumpAddr  in  32  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory returns `imem_rdata` for `imem_addr` this cycle.
- imem_rdata  in  32  fetched instruction, valid only when `imem_req & imem_ready`.
- Instruction_id  out  32  IF/ID instruction.
- PC_id  out  32  IF/ID PC.
- fetch_busy  out  1  request outstanding for more than one cycle (status/perf).

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is synchronous and active-high on port `reset`.
- Reset values, held while `reset`=1:
  - `Instruction_id`=NOP_INSTR, `PC_id`=0, `imem_req`=0, `imem_addr`=RESET_PC, `fetch_busy`=0.
  - Hold buffer empty, drop flag clear, state FETCH.
- First cycle after `reset` falls: `imem_req`=1, `imem_addr`=RESET_PC.
- Handshake rules:
  - At most one request outstanding.
  - `imem_addr` is stable while `imem_req`=1 and `imem_ready`=0.
  - A transfer completes when `req & ready` at a clock edge.
  - A new request may be issued in the cycle after a completion.
- Latency: with `imem_ready` tied to 1 and `IFWrite`=1, the instruction at address A appears on `Instruction_id` one cycle after the cycle A is on `imem_addr`. Throughput is 1 instruction per cycle, and the PC increments by 4.
- redirect = `IFWrite & (Branch|Jump)`. Branch/Jump are ignored while `IFWrite`=0; decode re-evaluates them after the stall.
- States:
  - FETCH: request for `fetch_pc` active.
    - On completion with `IFWrite`=1 and no redirect: load IF/ID with {`imem_rdata`, `fetch_pc`}; `fetch_pc` += 4; stay in FETCH.
    - On completion with `IFWrite`=0: store data and PC in the hold buffer; go to HOLD; `imem_req`=0.
    - No completion with `IFWrite`=1: IF/ID loads NOP_INSTR (`PC_id` unchanged).
  - HOLD: buffer full, `imem_req`=0.
    - When `IFWrite`=1 and no redirect: load IF/ID from the buffer; `fetch_pc` += 4; go to FETCH.
  - DRAIN: a redirect arrived while a request was pending and not ready.
    - Keep the old `imem_addr` and `imem_req`=1 until completion, then discard `imem_rdata`.
    - After that, go to FETCH at the stored target.
- Redirect, from any state:
  - IF/ID loads NOP_INSTR.
  - Hold-buffer contents are discarded.
  - A same-cycle completion is discarded.
  - `fetch_pc` ← `JumpAddr`.
  - Next state: FETCH if no request is left pending, else DRAIN.
  - A second redirect during DRAIN overwrites the stored target.
- `IFWrite`=0 in any state: IF/ID holds its value and the PC does not advance.
- `fetch_busy` = `imem_req & ~imem_ready` held from the previous cycle (registered).
- `JumpAddr` bits [1:0] are forced to 0.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-request: the outstanding request is abandoned, with no drain. The memory model must tolerate `req` dropping.

Decomposition:
- Shared pipeline package: NOP_INSTR, the fetch FSM enum {FETCH, HOLD, DRAIN}, and the IF/ID record type {instr, pc}.
- One natural sub-module, `ifid_reg`, holding the IF/ID register with load / hold / flush-to-NOP controls. The PC, buffer and FSM stay in the top module.

Test Plan:
- Straight line: reset, then `imem_ready`=1 and `IFWrite`=1 for 5 cycles. Required: `imem_addr` 0,4,8,…; `PC_id` 0,4,8 starting one cycle later; `Instruction_id` matches memory.
- Stall: `IFWrite`=0 for 2 cycles while fetching 0x8. Required: IF/ID holds 0x4 and its instruction; `imem_req`=0 after the 0x8 completion; 0x8 is presented on the first `IFWrite`=1; no duplicate or lost instruction.
- Taken branch: `Branch`=1, `JumpAddr`=0x40 while decode holds 0x4. Required: `Instruction_id`=0x00000013 next cycle; wrong-path 0x8 is discarded; `imem_addr`=0x40 next cycle.
- Drain: memory adds 3 wait states on 0x10, and `Jump`=1 to 0x80 during the wait. Required: `imem_addr` stays 0x10 until ready; that data is dropped; then 0x80 is fetched; only 0x80 reaches decode.
- Stall plus redirect: `IFWrite`=0 with `Branch`=1. Required: no redirect. Then `IFWrite`=1 with `Branch`=1. Required: buffer flushed, NOP inserted, fetch at target.
- Reset mid-operation: `reset`=1 during DRAIN. Required: all outputs at reset values next edge; fetch resumes at RESET_PC.
